reaction_round_ctrl: RTL

Parametrised game core for the Dexterity Dash reaction game. It drives an N_CH-wide one-hot target onto the LED header and accepts a matching player pattern only after the pattern has been stable for a set time. It counts hits with a saturating score and runs a per-second round countdown. It replaces the combinational match/shift logic with a single clocked state machine: wrap-around targets, random mode, a release-before-next-hit rule and a decimal-ready time output. The top level feeds `score` and `time_left` into the existing BCD/7-seg path.

---
 rtl/reaction_round_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl
// Game core for the reaction game. It shows a one-hot target, scores a hit
// once the synchronised player pattern has matched for HOLD_CYCLES cycles in
// a row, and requires a full release before the next hit can count. A
// per-second countdown ends the round.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      one-cycle pulse; starts or restarts a round (wins over everything)
//   mode       0 = sequential walk, 1 = random targets; sampled on start
//   player_in  raw switch pattern, asynchronous to clk
//   target     one-hot target, zero outside PLAY/RELEASE
//   score      saturating hit count for this round
//   time_left  remaining seconds
//   hit_pulse  one-cycle pulse per accepted hit
//   round_done high in DONE until the next start
//   state      debug: IDLE=0, PLAY=1, RELEASE=2, DONE=3
module reaction_round_ctrl #(
  parameter int          N_CH        = 8,
  parameter int          TICK_DIV    = 50000000,
  parameter int          ROUND_SECS  = 60,
  parameter int          HOLD_CYCLES = 16,
  parameter int          SCORE_W     = 8,
  parameter int          TIME_W      = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               mode,
  input  logic [N_CH-1:0]    player_in,
  output logic [N_CH-1:0]    target,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic               hit_pulse,
  output logic               round_done,
  output logic [1:0]         state
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]   PRE_RELOAD = PRE_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(ROUND_SECS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX    = IDX_W'(N_CH - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [IDX_W-1:0] lfsr_index(input logic [15:0] v);
    return IDX_W'(v % 16'(N_CH));
  endfunction

  function automatic logic [IDX_W-1:0] inc_index(input logic [IDX_W-1:0] i);
    return (i == IDX_MAX) ? {IDX_W{1'b0}} : i + IDX_W'(1);
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_CH-1:0] v;
    v    = {N_CH{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [N_CH-1:0]    sync_meta_r, pin_s;
  logic [N_CH-1:0]    target_r, target_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [SCORE_W-1:0] score_r, score_nxt_s;
  logic [TIME_W-1:0]  time_r, time_nxt_s;
  logic [PRE_W-1:0]   presc_r, presc_nxt_s;
  logic [HOLD_W-1:0]  hold_r, hold_nxt_s;
  logic               hit_r, hit_nxt_s;
  logic               done_r, done_nxt_s;
  logic               mode_r, mode_nxt_s;
  logic [15:0]        lfsr_r;
  logic [IDX_W-1:0]   rnd_idx_s, step_idx_s;

  // Two-flop synchroniser for the asynchronous player pattern.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_meta_r <= {N_CH{1'b0}};
      pin_s       <= {N_CH{1'b0}};
    end else begin
      sync_meta_r <= player_in;
      pin_s       <= sync_meta_r;
    end
  end

  // Free-running LFSR, advances in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Next target index; random mode never repeats the current index.
  always_comb begin
    rnd_idx_s = lfsr_index(lfsr_r);
    if (mode_r) begin
      step_idx_s = (rnd_idx_s == idx_r) ? inc_index(rnd_idx_s) : rnd_idx_s;
    end else begin
      step_idx_s = inc_index(idx_r);
    end
  end

  // Next-state and next-output logic for the round FSM.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    idx_nxt_s    = idx_r;
    score_nxt_s  = score_r;
    time_nxt_s   = time_r;
    presc_nxt_s  = presc_r;
    hold_nxt_s   = hold_r;
    hit_nxt_s    = 1'b0;
    done_nxt_s   = done_r;
    mode_nxt_s   = mode_r;

    if (start) begin
      state_nxt_s  = ST_PLAY;
      idx_nxt_s    = mode ? rnd_idx_s : {IDX_W{1'b0}};
      target_nxt_s = onehot(mode ? rnd_idx_s : {IDX_W{1'b0}});
      score_nxt_s  = {SCORE_W{1'b0}};
      time_nxt_s   = TIME_LOAD;
      presc_nxt_s  = PRE_RELOAD;
      hold_nxt_s   = {HOLD_W{1'b0}};
      done_nxt_s   = 1'b0;
      mode_nxt_s   = mode;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_PLAY: begin
          if (pin_s == target_r) begin
            if (hold_r == HOLD_LAST) begin
              hit_nxt_s    = 1'b1;
              score_nxt_s  = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_W'(1);
              idx_nxt_s    = step_idx_s;
              target_nxt_s = onehot(step_idx_s);
              hold_nxt_s   = {HOLD_W{1'b0}};
              state_nxt_s  = ST_RELEASE;
            end else begin
              hold_nxt_s = hold_r + HOLD_W'(1);
            end
          end else begin
            hold_nxt_s = {HOLD_W{1'b0}};
          end
        end
        ST_RELEASE: begin
          // Matching is suspended until every input is released.
          if (pin_s == {N_CH{1'b0}}) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_RELEASE;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase

      // Countdown; a hit on the final tick is still counted above.
      if ((state_r == ST_PLAY) || (state_r == ST_RELEASE)) begin
        if (presc_r == {PRE_W{1'b0}}) begin
          presc_nxt_s = PRE_RELOAD;
          time_nxt_s  = time_r - TIME_W'(1);
          if (time_r == TIME_W'(1)) begin
            state_nxt_s  = ST_DONE;
            target_nxt_s = {N_CH{1'b0}};
            hold_nxt_s   = {HOLD_W{1'b0}};
            done_nxt_s   = 1'b1;
          end else begin
            done_nxt_s = done_r;
          end
        end else begin
          presc_nxt_s = presc_r - PRE_W'(1);
        end
      end else begin
        presc_nxt_s = presc_r;
      end
    end
  end

  // Round state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      target_r <= {N_CH{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      score_r  <= {SCORE_W{1'b0}};
      time_r   <= TIME_LOAD;
      presc_r  <= PRE_RELOAD;
      hold_r   <= {HOLD_W{1'b0}};
      hit_r    <= 1'b0;
      done_r   <= 1'b0;
      mode_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      target_r <= target_nxt_s;
      idx_r    <= idx_nxt_s;
      score_r  <= score_nxt_s;
      time_r   <= time_nxt_s;
      presc_r  <= presc_nxt_s;
      hold_r   <= hold_nxt_s;
      hit_r    <= hit_nxt_s;
      done_r   <= done_nxt_s;
      mode_r   <= mode_nxt_s;
    end
  end

  assign target     = target_r;
  assign score      = score_r;
  assign time_left  = time_r;
  assign hit_pulse  = hit_r;
  assign round_done = done_r;
  assign state      = state_r;

endmodule
